// File: rtl/tune_player.sv
// tune_player: table-driven piezo tune sequencer; define TUNE_FAST_SIM_EN to run durations 16x faster
module tune_player #(
    parameter int PER_W  = 15,
    parameter int DUR_W  = 24,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PER_W-1:0]  wr_period,
    input  logic [DUR_W-1:0]  wr_dur,
    input  logic              wr_last,
    input  logic              go,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              abort,
    output logic              piezo,
    output logic              piezo_n,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] cur_addr
);
`ifdef TUNE_FAST_SIM_EN
    localparam int DUR_INC = 16;
`else
    localparam int DUR_INC = 1;
`endif
    localparam logic [DUR_W:0]    INC       = (DUR_W+1)'(DUR_INC);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_t;
    state_t            state;
    logic [PER_W-1:0]  mem_per [DEPTH];
    logic [DUR_W-1:0]  mem_dur [DEPTH];
    logic              mem_last [DEPTH];
    logic [PER_W-1:0]  period, freq_cnt;
    logic [DUR_W-1:0]  dur, dur_cnt;
    logic              last, audible, sound, note_end;
    always_ff @(posedge clk)
        if (wr_en) begin
            mem_per[wr_addr]  <= wr_period;
            mem_dur[wr_addr]  <= wr_dur;
            mem_last[wr_addr] <= wr_last;
        end
    assign audible  = state == PLAY && period >= PER_W'(2);
    assign sound    = audible && freq_cnt < (period >> 1);
    // widened compare so a duration near the top of the range cannot wrap
    assign note_end = {1'b0, dur_cnt} + INC >= {1'b0, dur};
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state    <= IDLE;
            piezo    <= 1'b0;
            piezo_n  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cur_addr <= '0;
            period   <= '0;
            dur      <= '0;
            last     <= 1'b0;
            freq_cnt <= '0;
            dur_cnt  <= '0;
        end else begin
            done    <= 1'b0;
            piezo   <= sound;
            piezo_n <= audible && !sound;
            if (abort && state != IDLE) begin
                state   <= IDLE;
                busy    <= 1'b0;
                piezo   <= 1'b0;
                piezo_n <= 1'b0;
            end else
                case (state)
                    IDLE:
                        if (go && !abort) begin
                            state    <= FETCH;
                            busy     <= 1'b1;
                            cur_addr <= start_addr;
                        end
                    FETCH: begin
                        period   <= mem_per[cur_addr];
                        dur      <= mem_dur[cur_addr];
                        last     <= mem_last[cur_addr];
                        freq_cnt <= '0;
                        dur_cnt  <= '0;
                        state    <= PLAY;
                    end
                    PLAY: begin
                        freq_cnt <= freq_cnt >= period - PER_W'(1) ? '0 : freq_cnt + 1'b1;
                        dur_cnt  <= dur_cnt + DUR_W'(DUR_INC);
                        if (note_end) begin
                            if (last) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state    <= FETCH;
                                cur_addr <= cur_addr == LAST_ADDR ? '0 : cur_addr + 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
        end
endmodule

// File: tb/tb_tune_player.sv
// tb_tune_player: randomized scoreboard bench for tune_player with a cycle-trace reference model
module tb_tune_player;
    localparam int PER_W = 15, DUR_W = 24, DEPTH = 16, AW = 4;
`ifdef TUNE_FAST_SIM_EN
    localparam int INC = 16;
`else
    localparam int INC = 1;
`endif
    typedef struct packed {
        logic          busy;
        logic          done;
        logic          pz;
        logic          pzn;
        logic          care;
        logic [AW-1:0] addr;
    } rec_t;
    logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, wr_last = 1'b0, go = 1'b0, abort = 1'b0;
    logic [AW-1:0]    wr_addr = '0, start_addr = '0;
    logic [PER_W-1:0] wr_period = '0;
    logic [DUR_W-1:0] wr_dur = '0;
    logic piezo, piezo_n, busy, done;
    logic [AW-1:0] cur_addr;
    rec_t q[$];
    rec_t e;
    int tper[DEPTH], tdur[DEPTH];
    bit tlast[DEPTH];
    int compared = 0, mismatched = 0, cyc = 0;

    tune_player dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_period(wr_period),
        .wr_dur(wr_dur), .wr_last(wr_last), .go(go), .start_addr(start_addr), .abort(abort),
        .piezo(piezo), .piezo_n(piezo_n), .busy(busy), .done(done), .cur_addr(cur_addr)
    );

    always #5 clk = ~clk;

    // with nothing queued the player must be silent and idle
    always @(negedge clk) begin
        cyc++;
        e = (q.size() > 0) ? q.pop_front() : rec_t'(0);
        compared++;
        if ({busy, done, piezo, piezo_n} !== {e.busy, e.done, e.pz, e.pzn} || (e.care && cur_addr !== e.addr)) begin
            mismatched++;
            $display("FAIL cyc%0d outputs: got busy=%b done=%b piezo=%b piezo_n=%b addr=%0d, want busy=%b done=%b piezo=%b piezo_n=%b addr=%0d (addr checked=%b)",
                     cyc, busy, done, piezo, piezo_n, cur_addr, e.busy, e.done, e.pz, e.pzn, e.addr, e.care);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int p, input int d, input bit l);
        wr_en = 1'b1; wr_addr = AW'(a); wr_period = PER_W'(p); wr_dur = DUR_W'(d); wr_last = l;
        step();
        wr_en = 1'b0;
        tper[a] = p; tdur[a] = d; tlast[a] = l;
    endtask

    task automatic fill();
        for (int i = 0; i < DEPTH; i++)
            wr(i, $urandom_range(12, 0), $urandom_range(40, 0), $urandom_range(3, 0) == 0);
        wr($urandom_range(DEPTH - 1, 0), $urandom_range(12, 2), $urandom_range(40, 1), 1'b1);
    endtask

    // kind: 0 plain, 1 abort (with go held) at record ev, 2 reset at record ev; ev<0 picks one at random
    task automatic play(input int sa, input int kind, input int ev_in);
        rec_t tr[$];
        int a, len, gp, gd, t, ev;
        bit ps, pn, h;
        ev = ev_in;
        tr.push_back(rec_t'(0));
        a = sa; ps = 1'b0; pn = 1'b0;
        for (int n = 0; n < DEPTH; n++) begin
            tr.push_back('{1'b1, 1'b0, ps, pn, 1'b1, AW'(a)});
            ps = 1'b0; pn = 1'b0;
            len = (tdur[a] + INC - 1) / INC;
            if (len < 1) len = 1;
            for (int k = 0; k < len; k++) begin
                tr.push_back('{1'b1, 1'b0, ps, pn, 1'b1, AW'(a)});
                if (tper[a] >= 2) begin
                    h = (k % tper[a]) < tper[a] / 2;
                    ps = h; pn = !h;
                end
            end
            if (tlast[a]) break;
            a = (a + 1) % DEPTH;
        end
        tr.push_back('{1'b0, 1'b1, ps, pn, 1'b1, AW'(a)});
        if (kind != 0 && ev < 0) ev = $urandom_range(tr.size() - 2, 1);
        if (kind == 1) while (tr.size() > ev + 1) void'(tr.pop_back());
        if (kind == 2) begin
            while (tr.size() > ev) void'(tr.pop_back());
            repeat (5) tr.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, AW'(0)});
        end
        go = 1'b1; start_addr = AW'(sa);
        q = tr;
        gp = $urandom_range(12, 0); gd = $urandom_range(40, 0);
        step();
        // overwrite the entry being fetched: the old contents must still be played
        go = 1'b0; wr_en = 1'b1; wr_addr = AW'(sa); wr_period = PER_W'(gp); wr_dur = DUR_W'(gd); wr_last = tlast[sa];
        if (kind != 0) begin
            repeat (ev - 1) begin step(); wr_en = 1'b0; end
            if (kind == 1) begin abort = 1'b1; go = 1'b1; end else rst = 1'b1;
            step();
            abort = 1'b0; go = 1'b0; wr_en = 1'b0;
            if (kind == 2) begin repeat (2) step(); rst = 1'b0; end
        end
        step();
        wr_en = 1'b0;
        tper[sa] = gp; tdur[sa] = gd;
        t = 0;
        while (q.size() > 0 && t < 20000) begin step(); t++; end
        if (q.size() > 0) begin
            compared++; mismatched++;
            $display("FAIL drain: %0d expected records left, want 0", q.size());
            q.delete();
        end
        step(); step();
    endtask

    initial begin
        int r;
        repeat (3) step();
        rst = 1'b0;
        step();
        fill();
        wr(0, 8, 20, 1'b1);
        play(0, 0, -1);
        wr(5, 6, 12, 1'b0); wr(6, 0, 10, 1'b0); wr(7, 10, 30, 1'b1);
        play(5, 0, -1);
        wr(15, 4, 8, 1'b0); wr(0, 6, 10, 1'b1);
        play(15, 0, -1);
        wr(0, 8, 20, 1'b1);
        play(0, 1, 8);
        play(0, 0, -1);
        wr(5, 6, 12, 1'b0); wr(6, 0, 10, 1'b0); wr(7, 10, 30, 1'b1);
        play(5, 2, 10);
        play(5, 0, -1);
        wr(3, 8, 64, 1'b1); wr(4, 8, 0, 1'b1);
        play(3, 0, -1);
        play(4, 0, -1);
        for (int i = 0; i < 40; i++) begin
            fill();
            r = $urandom_range(7, 0);
            play($urandom_range(DEPTH - 1, 0), r == 0 ? 2 : (r < 3 ? 1 : 0), -1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
